// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue controller.
// Op and FSM encodings, the half-precision quiet NaN, the default wait bound
// and the per-op flag masking helper.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_DIV = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_HOLD  = 2'b11
    } state_e;

    localparam logic [15:0] FP16_QNAN       = 16'h7E00;
    localparam int          FPU_TIMEOUT_DEF = 64;
    localparam logic [4:0]  FLAG_TIMEOUT    = 5'b10000;

    // Only the flags produced by the selected unit are forwarded; bit 4 of
    // the FPU flag bus has no meaning here, so callers pass bits [3:0].
    function automatic logic [4:0] mask_flags(op_e op, logic [3:0] f);
        case (op)
            OP_MUL:  return {3'b000, f[1:0]};
            OP_DIV:  return {1'b0, f[3:2], 2'b00};
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl.sv
// Purpose: accepts one FP16 command at a time, launches it on the FPU, waits
//   for the matching unit strobe (or a timeout) and holds the result.
// Latency: accept -> fpu_start 1 cycle; strobe -> res_valid 1 cycle (min 3).
// Backpressure: cmd_ready only in IDLE; result held while res_ready is low.
// Ports: clk/reset (sync, active-low); cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b
//   host command; fpu_a/fpu_b/fpu_start FPU launch; add/mul/div_valid with
//   sum/product/quotient/fpu_flags FPU completion; res_valid/res_ready/
//   res_data/res_flags/res_err result channel.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int TIMEOUT = FPU_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    output logic [15:0] fpu_a,
    output logic [15:0] fpu_b,
    output logic        fpu_start,
    input  logic        add_valid,
    input  logic        mul_valid,
    input  logic        div_valid,
    input  logic [15:0] sum,
    input  logic [15:0] product,
    input  logic [15:0] quotient,
    input  logic [4:0]  fpu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [4:0]  res_flags,
    output logic        res_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    op_e           op_q;
    logic [15:0]   a_q, b_q;
    logic [CW-1:0] cnt_q;
    logic [15:0]   res_data_q;
    logic [4:0]    res_flags_q;
    logic          res_err_q;

    logic          sel_vld;
    logic [15:0]   sel_res;
    logic          timeout_hit;
    logic          unused_flag4;

    assign unused_flag4 = fpu_flags[4];

    // Only the unit matching the in-flight op may complete the command.
    always_comb begin
        sel_vld = 1'b0;
        sel_res = 16'h0000;
        case (op_q)
            OP_ADD:  begin sel_vld = add_valid; sel_res = sum;      end
            OP_MUL:  begin sel_vld = mul_valid; sel_res = product;  end
            OP_DIV:  begin sel_vld = div_valid; sel_res = quotient; end
            default: begin sel_vld = 1'b0;      sel_res = 16'h0000; end
        endcase
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid)
                    state_d = (op_e'(cmd_op) == OP_RSV) ? S_HOLD : S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (sel_vld || timeout_hit) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        cmd_ready = (state_q == S_IDLE);
        fpu_start = (state_q == S_ISSUE);
        res_valid = (state_q == S_HOLD);
    end

    // Datapath: operand capture, wait counter and result capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q        <= OP_ADD;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            cnt_q       <= '0;
            res_data_q  <= 16'h0000;
            res_flags_q <= 5'b00000;
            res_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q        <= op_e'(cmd_op);
                        a_q         <= cmd_a;
                        b_q         <= cmd_b;
                        res_data_q  <= 16'h0000;
                        res_flags_q <= 5'b00000;
                        res_err_q   <= (op_e'(cmd_op) == OP_RSV);
                    end
                end
                S_ISSUE: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // A strobe in the timeout cycle still delivers its result.
                    if (sel_vld) begin
                        res_data_q  <= sel_res;
                        res_flags_q <= mask_flags(op_q, fpu_flags[3:0]);
                    end else if (timeout_hit) begin
                        res_data_q  <= FP16_QNAN;
                        res_flags_q <= FLAG_TIMEOUT;
                        res_err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fpu_a     = a_q;
    assign fpu_b     = b_q;
    assign res_data  = res_data_q;
    assign res_flags = res_flags_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl with TIMEOUT=8: table of commands with hand-derived
// expected results, scoreboard queue, plus reset and backpressure sequences.
module tb_fpu_issue_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a, cmd_b, fpu_a, fpu_b;
    logic        fpu_start;
    logic        add_valid, mul_valid, div_valid;
    logic [15:0] sum, product, quotient;
    logic [4:0]  fpu_flags;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [4:0]  res_flags;
    logic        res_err;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.TIMEOUT(T)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_start(fpu_start),
        .add_valid(add_valid), .mul_valid(mul_valid), .div_valid(div_valid),
        .sum(sum), .product(product), .quotient(quotient), .fpu_flags(fpu_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags), .res_err(res_err)
    );

    // dly: cycles after the fpu_start cycle that the selected strobe is
    // driven (0 = never); stray: cycle at which the other units pulse.
    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b;
        int          dly, stray;
        logic [15:0] s, p, q;
        logic [4:0]  fl;
        int          hold;
        logic [15:0] e_data;
        logic [4:0]  e_flags;
        logic        e_err;
        int          e_lat;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [4:0]  flags;
        logic        err;
        int          lat;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 16'h0; cmd_b = 16'h0;
        add_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0;
        sum = 16'h0; product = 16'h0; quotient = 16'h0; fpu_flags = 5'h0;
        res_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc;
        int   guard;
        exp_t e;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("cmd_ready_before_accept", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_op = v.op; cmd_a = v.a; cmd_b = v.b;
        sum = v.s; product = v.p; quotient = v.q; fpu_flags = v.fl;
        sb.push_back('{v.e_data, v.e_flags, v.e_err, v.e_lat});
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("fpu_start_after_accept", {31'b0, fpu_start}, {31'b0, (v.op != 2'b11)});
        chk("fpu_a", {16'b0, fpu_a}, {16'b0, v.a});
        chk("fpu_b", {16'b0, fpu_b}, {16'b0, v.b});
        cyc = 0;
        while (!res_valid && cyc < 40) begin
            add_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0;
            if (cyc != 0 && cyc == v.dly) begin
                add_valid = (v.op == 2'b00);
                mul_valid = (v.op == 2'b01);
                div_valid = (v.op == 2'b10);
            end
            if (cyc != 0 && cyc == v.stray) begin
                add_valid = (v.op != 2'b00);
                mul_valid = (v.op != 2'b01);
                div_valid = (v.op != 2'b10);
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !res_valid)
                chk("fpu_start_one_cycle", {31'b0, fpu_start}, 32'd0);
        end
        add_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0;
        chk("res_valid_seen", {31'b0, res_valid}, 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("res_data", {16'b0, res_data}, {16'b0, e.data});
            chk("res_flags", {27'b0, res_flags}, {27'b0, e.flags});
            chk("res_err", {31'b0, res_err}, {31'b0, e.err});
            chk("latency", cyc, e.lat);
            // Backpressure: result frozen, no new command taken.
            for (int h = 0; h < v.hold; h++) begin
                cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 16'h1234; cmd_b = 16'h5678;
                @(negedge clk);
                chk("hold_res_valid", {31'b0, res_valid}, 32'd1);
                chk("hold_res_data", {16'b0, res_data}, {16'b0, e.data});
                chk("hold_res_flags", {27'b0, res_flags}, {27'b0, e.flags});
                chk("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
                chk("hold_fpu_a", {16'b0, fpu_a}, {16'b0, v.a});
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_handshake_res_valid", {31'b0, res_valid}, 32'd0);
        chk("post_handshake_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    endtask

    initial begin
        //         op     a        b        dly st s        p        q        fl     hold e_data   e_fl   err lat
        vecs[0] = '{2'b00, 16'h3C00, 16'h3C00, 3, 0, 16'h4000, 16'h1111, 16'h2222, 5'h1F, 0, 16'h4000, 5'h00, 0, 4};
        vecs[1] = '{2'b01, 16'h4000, 16'h4200, 2, 1, 16'h3333, 16'h4600, 16'h5555, 5'h01, 0, 16'h4600, 5'h01, 0, 3};
        vecs[2] = '{2'b01, 16'h3E00, 16'h3E00, 1, 0, 16'h1111, 16'h4080, 16'h2222, 5'h1F, 0, 16'h4080, 5'h03, 0, 2};
        vecs[3] = '{2'b10, 16'h4400, 16'h4000, 4, 2, 16'h1111, 16'h2222, 16'h4000, 5'h1F, 0, 16'h4000, 5'h0C, 0, 5};
        vecs[4] = '{2'b11, 16'h1234, 16'h5678, 2, 0, 16'h1111, 16'h2222, 16'h3333, 5'h1F, 0, 16'h0000, 5'h00, 1, 0};
        vecs[5] = '{2'b10, 16'h3C00, 16'h0000, 0, 0, 16'h1111, 16'h2222, 16'h3333, 5'h0F, 0, 16'h7E00, 5'h10, 1, 9};
        vecs[6] = '{2'b10, 16'h3C00, 16'h4000, 8, 0, 16'h1111, 16'h2222, 16'h3800, 5'h04, 0, 16'h3800, 5'h04, 0, 9};
        vecs[7] = '{2'b01, 16'h7BFF, 16'h7BFF, 9, 0, 16'h1111, 16'h7C00, 16'h2222, 5'h01, 0, 16'h7E00, 5'h10, 1, 9};
        vecs[8] = '{2'b00, 16'h4000, 16'h3C00, 1, 0, 16'h4200, 16'h1111, 16'h2222, 5'h00, 5, 16'h4200, 5'h00, 0, 2};

        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_fpu_start", {31'b0, fpu_start}, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_err", {31'b0, res_err}, 32'd0);
        chk("rst_res_data", {16'b0, res_data}, 32'd0);
        chk("rst_res_flags", {27'b0, res_flags}, 32'd0);
        chk("rst_fpu_a", {16'b0, fpu_a}, 32'd0);
        chk("rst_fpu_b", {16'b0, fpu_b}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset while waiting on an add; a late add_valid must not produce a result.
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 16'h3C00; cmd_b = 16'h4000; sum = 16'h4200;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("midrst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("midrst_fpu_a", {16'b0, fpu_a}, 32'd0);
        add_valid = 1'b1;
        @(negedge clk);
        add_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("late_strobe_no_result", {31'b0, res_valid}, 32'd0);
        end
        chk("late_strobe_fpu_start", {31'b0, fpu_start}, 32'd0);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
